dff_pipe: RTL and testbench

Parametrised pipeline register built from the library's async-reset D flip-flop. It is a WIDTH-bit by DEPTH-stage delay line with per-stage valid tracking, a global stall enable, a synchronous flush, and a serial scan chain through every data bit. It is the standard staging element between multiplier and accumulator stages in the matrix-multiply datapath.

---
 rtl/dff_pipe.sv | 74 +++++++
 tb/tb_dff_pipe.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/dff_pipe.sv
// WIDTH x DEPTH pipeline register with per-stage valid, stall, flush and a
// serial scan chain threaded through every data bit.
module dff_pipe #(
  parameter int unsigned       WIDTH     = 8,
  parameter int unsigned       DEPTH     = 4,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  localparam int unsigned      CW        = $clog2(DEPTH + 1)
) (
  input  logic             gclk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             vin,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             vout,
  output logic [CW-1:0]    cnt,
  input  logic             scan_en,
  input  logic             scan_in,
  output logic             scan_out
);

  localparam int unsigned NB = WIDTH * DEPTH;

  // Stage i occupies data bits [i*WIDTH +: WIDTH]; bit order matches the scan chain.
  logic [NB-1:0]    data_q, data_d;
  logic [DEPTH-1:0] vld_q,  vld_d;
  logic [CW-1:0]    cnt_c;

  // Next state: scan shift > flush > advance > hold.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (scan_en) begin
      data_d[0] = scan_in;
      for (int i = 1; i < int'(NB); i++) begin
        data_d[i] = data_q[i-1];
      end
    end else if (flush) begin
      vld_d = '0;
    end else if (en) begin
      data_d[WIDTH-1:0] = d;
      vld_d[0]          = vin;
      for (int i = 1; i < int'(DEPTH); i++) begin
        data_d[i*WIDTH +: WIDTH] = data_q[(i-1)*WIDTH +: WIDTH];
        vld_d[i]                 = vld_q[i-1];
      end
    end
  end

  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      data_q <= {DEPTH{RESET_VAL}};
      vld_q  <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  // Occupancy is a pure function of the valid registers.
  always_comb begin
    cnt_c = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      cnt_c = cnt_c + CW'(vld_q[i]);
    end
  end

  assign q        = data_q[NB-1 -: WIDTH];
  assign vout     = vld_q[DEPTH-1];
  assign scan_out = data_q[NB-1];
  assign cnt      = cnt_c;

endmodule

// File: tb/tb_dff_pipe.sv
// Scoreboard bench for dff_pipe: streaming, stall, flush, scan and async reset.
module tb_dff_pipe;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;
  localparam logic [7:0]  RV    = 8'hA5;

  logic             gclk = 1'b0;
  logic             rst, en, flush, vin, scan_en, scan_in;
  logic [WIDTH-1:0] d, q;
  logic             vout, scan_out;
  logic [CW-1:0]    cnt;

  int checks   = 0;
  int failures = 0;

  logic [7:0]       sb_q[$];
  logic [DEPTH-1:0] mv;
  logic [31:0]      pat;

  dff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RV)) dut (
    .gclk(gclk), .rst(rst), .en(en), .flush(flush), .vin(vin), .d(d),
    .q(q), .vout(vout), .cnt(cnt),
    .scan_en(scan_en), .scan_in(scan_in), .scan_out(scan_out)
  );

  always #5 gclk = ~gclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int mcnt();
    int n = 0;
    for (int i = 0; i < int'(DEPTH); i++) n += int'(mv[i]);
    return n;
  endfunction

  // One clock with the given controls; update the model and compare.
  task automatic cyc(input logic e, input logic fl, input logic vi, input logic [7:0] dd,
                     input logic se, input logic si);
    en = e; flush = fl; vin = vi; d = dd; scan_en = se; scan_in = si;
    @(posedge gclk); #1;
    if (!se) begin
      if (fl) begin
        mv = '0;
        sb_q.delete();
      end else if (e) begin
        mv = {mv[DEPTH-2:0], vi};
        if (vi) sb_q.push_back(dd);
        if (mv[DEPTH-1]) begin
          chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
          if (sb_q.size() != 0) chk("q_data", 32'(q), 32'(sb_q.pop_front()));
        end
      end
    end
    chk("vout", 32'(vout), 32'(mv[DEPTH-1]));
    chk("cnt", 32'(cnt), 32'(mcnt()));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_q"}, 32'(q), 32'(RV));
    chk({tag, "_vout"}, 32'(vout), 32'd0);
    chk({tag, "_cnt"}, 32'(cnt), 32'd0);
    chk({tag, "_scan_out"}, 32'(scan_out), 32'd1);
  endtask

  // Assert rst between edges, check without a clock edge, then release.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1 chk_reset_vals(tag);
    mv = '0;
    sb_q.delete();
    en = 0; flush = 0; vin = 0; scan_en = 0; scan_in = 0;
    @(posedge gclk); #1;
    rst = 1'b0;
  endtask

  int stream_cnt_exp[5] = '{1, 2, 3, 4, 4};

  initial begin
    rst = 1'b1; en = 0; flush = 0; vin = 0; d = '0; scan_en = 0; scan_in = 0;
    mv = '0;
    pat = 32'h1234_5678;
    #2 chk_reset_vals("por");
    @(posedge gclk); #1;
    @(posedge gclk); #1;
    rst = 1'b0;

    // Streaming 1..5 then drain.
    for (int k = 0; k < 5; k++) begin
      cyc(1, 0, 1, 8'(k + 1), 0, 0);
      chk("stream_cnt", 32'(cnt), 32'(stream_cnt_exp[k]));
    end
    for (int k = 0; k < 4; k++) cyc(1, 0, 0, 8'h00, 0, 0);

    // Stall for two cycles after the second word.
    cyc(1, 0, 1, 8'd1, 0, 0);
    cyc(1, 0, 1, 8'd2, 0, 0);
    for (int k = 0; k < 2; k++) begin
      cyc(0, 0, 1, 8'hEE, 0, 0);
      chk("stall_cnt", 32'(cnt), 32'd2);
    end
    for (int k = 3; k <= 5; k++) cyc(1, 0, 1, 8'(k), 0, 0);
    for (int k = 0; k < 4; k++) cyc(1, 0, 0, 8'h00, 0, 0);

    // Fill, then flush together with vin/en.
    for (int k = 0; k < 4; k++) cyc(1, 0, 1, 8'(8'h10 + k), 0, 0);
    chk("full_cnt", 32'(cnt), 32'd4);
    cyc(1, 1, 1, 8'h99, 0, 0);
    chk("flush_cnt", 32'(cnt), 32'd0);
    chk("flush_vout", 32'(vout), 32'd0);
    chk("flush_q", 32'(q), 32'h10);
    cyc(1, 0, 1, 8'h42, 0, 0);
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 8'h00, 0, 0);
    chk("flush_latency_q", 32'(q), 32'h42);

    async_reset("arst");

    // First edge after reset release is a normal edge.
    cyc(1, 0, 1, 8'h5A, 0, 0);
    chk("rel_cnt", 32'(cnt), 32'd1);
    for (int k = 0; k < 3; k++) cyc(1, 0, 0, 8'h00, 0, 0);
    chk("rel_q", 32'(q), 32'h5A);

    // Scan load with valids present; en/flush asserted on some shifts.
    cyc(1, 0, 1, 8'd1, 0, 0);
    cyc(1, 0, 0, 8'd2, 0, 0);
    cyc(1, 0, 1, 8'd3, 0, 0);
    for (int k = 0; k < 32; k++) begin
      cyc((k % 3) == 0, (k % 3) == 0, 1, 8'hFF, 1, pat[31-k]);
    end
    chk("scan_load_q", 32'(q), 32'h12);
    chk("scan_load_cnt", 32'(cnt), 32'd2);
    for (int k = 0; k < 32; k++) begin
      chk("scan_unload_bit", 32'(scan_out), 32'(pat[31-k]));
      if (k == 8) chk("scan_unload_q", 32'(q), 32'h34);
      cyc(0, 0, 0, 8'h00, 1, 0);
    end
    chk("scan_clear_q", 32'(q), 32'h00);
    cyc(0, 0, 0, 8'h00, 0, 0);
    chk("scan_exit_cnt", 32'(cnt), 32'd2);
    cyc(0, 1, 0, 8'h00, 0, 0);

    // Reset during a scan with flush/en also asserted.
    cyc(1, 0, 1, 8'h77, 0, 0);
    for (int k = 0; k < 5; k++) cyc(1, 1, 1, 8'h00, 1, 1'b0);
    chk("prio_cnt", 32'(cnt), 32'd1);
    scan_en = 1; flush = 1; en = 1;
    async_reset("scan_rst");
    cyc(0, 0, 0, 8'h00, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
